// File: rtl/inst_gen_pkg.sv
// Shared types and instruction-word layout for the tile instruction generator.
// Optional build macro INST_GEN_ACC_EN lives in inst_gen.sv.
package inst_gen_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WFETCH,
    S_KLOAD,
    S_AFETCH,
    S_EXEC,
    S_DRAIN,
    S_RDOUT
  } state_t;

  localparam int INST_W       = 64;
  localparam int ADDR_FIELD_W = 11;

  localparam int BIT_DEBUG       = 63;
  localparam int BIT_PASS_PSUM   = 39;
  localparam int BIT_RECALL_PSUM = 38;
  localparam int BIT_L1_WR       = 37;
  localparam int BIT_OUT_STAT    = 36;
  localparam int BIT_REN_PMEM    = 35;
  localparam int BIT_PASSTHROUGH = 34;
  localparam int BIT_ACC         = 33;
  localparam int BIT_CEN_PMEM    = 32;
  localparam int BIT_WEN_PMEM    = 31;
  localparam int A_PMEM_LSB      = 20;
  localparam int BIT_CEN_XMEM    = 19;
  localparam int BIT_WEN_XMEM    = 18;
  localparam int A_XMEM_LSB      = 7;
  localparam int BIT_OFIFO_RD    = 6;
  localparam int BIT_IFIFO_WR    = 5;
  localparam int BIT_IFIFO_RD    = 4;
  localparam int BIT_L0_RD       = 3;
  localparam int BIT_L0_WR       = 2;
  localparam int BIT_EXECUTE     = 1;
  localparam int BIT_LOAD        = 0;

  // Both memories deselected and write-disabled (active-low enables held high).
  localparam logic [INST_W-1:0] IDLE_WORD =
      (64'd1 << BIT_CEN_PMEM) | (64'd1 << BIT_WEN_PMEM) |
      (64'd1 << BIT_CEN_XMEM) | (64'd1 << BIT_WEN_XMEM);

endpackage

// File: rtl/inst_gen_if.sv
// Tile-launch / instruction bus between the controller (master) and inst_gen (slave).
// start is a single-cycle request, honoured only while busy is low; done pulses once per tile.
interface inst_gen_if
  import inst_gen_pkg::*;
#(
  parameter int AW = 11
);
  logic                start;
  logic [AW-1:0]       w_base;
  logic [AW-1:0]       x_base;
  logic [AW-1:0]       p_base;
  logic [AW-1:0]       n_act;
  logic                first_tile;
  logic                ofifo_valid;
  logic [INST_W-1:0]   inst;
  logic                busy;
  logic                done;
  state_t              state;

  modport master (
    output start, w_base, x_base, p_base, n_act, first_tile, ofifo_valid,
    input  inst, busy, done, state
  );

  modport slave (
    input  start, w_base, x_base, p_base, n_act, first_tile, ofifo_valid,
    output inst, busy, done, state
  );
endinterface

// File: rtl/inst_gen_cnt.sv
// Loadable up-counter with a terminal-count flag; one instance per tile phase.
module inst_gen_cnt #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         en,
  input  logic [W-1:0] last,
  output logic [W-1:0] count,
  output logic         tc
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

  assign tc = (count == last);

endmodule

// File: rtl/inst_gen.sv
// Tile instruction generator: walks weight fetch, kernel load, activation fetch, execute,
// drain and psum readout, emitting one registered 64-bit core instruction per cycle.
// Build macro INST_GEN_ACC_EN enables read-accumulate-write psum readout for non-first tiles.
module inst_gen
  import inst_gen_pkg::*;
#(
  parameter int ROW = 8,
  parameter int COL = 8,
  parameter int AW  = 11
) (
  input logic         clk,
  input logic         reset,
  inst_gen_if.slave   bus
);

  localparam int CW = AW + 1;

  state_t            state;
  state_t            state_nx;
  logic [AW-1:0]     w_base_q;
  logic [AW-1:0]     x_base_q;
  logic [AW-1:0]     p_base_q;
  logic [AW-1:0]     n_act_q;
  logic [CW-1:0]     n_ext;
  logic              acc_mode;
  logic              launch;

  logic [CW-1:0]     wf_cnt, kl_cnt, af_cnt, ex_cnt, rd_cnt;
  logic              wf_tc, kl_tc, af_tc, ex_tc, rd_tc;
  logic [CW-1:0]     rd_last;
  logic [AW-1:0]     rd_k;

  logic [INST_W-1:0] word;
  logic [INST_W-1:0] inst_q;
  logic              done_q;

  assign launch = (state == S_IDLE) && bus.start;
  assign n_ext  = {1'b0, n_act_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      w_base_q <= '0;
      x_base_q <= '0;
      p_base_q <= '0;
      n_act_q  <= '0;
    end else if (launch) begin
      w_base_q <= bus.w_base;
      x_base_q <= bus.x_base;
      p_base_q <= bus.p_base;
      n_act_q  <= bus.n_act;
    end
  end

`ifdef INST_GEN_ACC_EN
  logic first_tile_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      first_tile_q <= 1'b0;
    end else if (launch) begin
      first_tile_q <= bus.first_tile;
    end
  end

  assign acc_mode = ~first_tile_q;
`else
  assign acc_mode = 1'b0;
`endif

  // Accumulate readout spends a read cycle and a write cycle on each psum word.
  assign rd_last = acc_mode ? ((n_ext << 1) - CW'(1)) : (n_ext - CW'(1));

  inst_gen_cnt #(.W(CW)) u_wf_cnt (
    .clk(clk), .reset(reset), .load(state != S_WFETCH), .load_value('0),
    .en(state == S_WFETCH), .last(CW'(ROW)), .count(wf_cnt), .tc(wf_tc)
  );

  inst_gen_cnt #(.W(CW)) u_kl_cnt (
    .clk(clk), .reset(reset), .load(state != S_KLOAD), .load_value('0),
    .en(state == S_KLOAD), .last(CW'(COL - 1)), .count(kl_cnt), .tc(kl_tc)
  );

  inst_gen_cnt #(.W(CW)) u_af_cnt (
    .clk(clk), .reset(reset), .load(state != S_AFETCH), .load_value('0),
    .en(state == S_AFETCH), .last(n_ext), .count(af_cnt), .tc(af_tc)
  );

  inst_gen_cnt #(.W(CW)) u_ex_cnt (
    .clk(clk), .reset(reset), .load(state != S_EXEC), .load_value('0),
    .en(state == S_EXEC), .last(n_ext - CW'(1)), .count(ex_cnt), .tc(ex_tc)
  );

  inst_gen_cnt #(.W(CW)) u_rd_cnt (
    .clk(clk), .reset(reset), .load(state != S_RDOUT), .load_value('0),
    .en(state == S_RDOUT), .last(rd_last), .count(rd_cnt), .tc(rd_tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (bus.start)       state_nx = S_WFETCH;
      S_WFETCH: if (wf_tc)           state_nx = S_KLOAD;
      S_KLOAD:  if (kl_tc)           state_nx = S_AFETCH;
      S_AFETCH: if (af_tc)           state_nx = S_EXEC;
      S_EXEC:   if (ex_tc)           state_nx = S_DRAIN;
      S_DRAIN:  if (bus.ofifo_valid) state_nx = S_RDOUT;
      S_RDOUT:  if (rd_tc)           state_nx = S_IDLE;
      default:                       state_nx = S_IDLE;
    endcase
  end

  // Fetch phases run one extra cycle: l0_wr trails the xmem read by one cycle.
  always_comb begin
    word = IDLE_WORD;
    rd_k = acc_mode ? rd_cnt[AW:1] : rd_cnt[AW-1:0];
    case (state)
      S_WFETCH: begin
        if (wf_cnt < CW'(ROW)) begin
          word[BIT_CEN_XMEM] = 1'b0;
          word[A_XMEM_LSB +: ADDR_FIELD_W] = ADDR_FIELD_W'(w_base_q + wf_cnt[AW-1:0]);
        end
        if (wf_cnt != '0) word[BIT_L0_WR] = 1'b1;
      end
      S_KLOAD: begin
        word[BIT_LOAD]  = 1'b1;
        word[BIT_L0_RD] = 1'b1;
      end
      S_AFETCH: begin
        if (af_cnt < n_ext) begin
          word[BIT_CEN_XMEM] = 1'b0;
          word[A_XMEM_LSB +: ADDR_FIELD_W] = ADDR_FIELD_W'(x_base_q + af_cnt[AW-1:0]);
        end
        if (af_cnt != '0) word[BIT_L0_WR] = 1'b1;
      end
      S_EXEC: begin
        word[BIT_EXECUTE] = 1'b1;
        word[BIT_L0_RD]   = 1'b1;
      end
      S_RDOUT: begin
        word[BIT_CEN_PMEM] = 1'b0;
        word[A_PMEM_LSB +: ADDR_FIELD_W] = ADDR_FIELD_W'(p_base_q + rd_k);
        if (acc_mode && !rd_cnt[0]) begin
          word[BIT_REN_PMEM] = 1'b1;
        end else if (acc_mode) begin
          word[BIT_WEN_PMEM] = 1'b0;
          word[BIT_OFIFO_RD] = 1'b1;
          word[BIT_ACC]      = 1'b1;
        end else begin
          word[BIT_WEN_PMEM]    = 1'b0;
          word[BIT_OFIFO_RD]    = 1'b1;
          word[BIT_PASSTHROUGH] = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inst_q <= IDLE_WORD;
      done_q <= 1'b0;
    end else begin
      inst_q <= word;
      done_q <= (state == S_RDOUT) && rd_tc;
    end
  end

  assign bus.inst  = inst_q;
  assign bus.busy  = (state != S_IDLE);
  assign bus.done  = done_q;
  assign bus.state = state;

endmodule
